// File: rtl/draw_pkg.sv
// draw_pkg: shared types and constants for the per-frame draw sequencer.
//   - draw_state_e       : sequencer FSM states
//   - DEFAULT_X_W/Y_W/COLOUR_W : default pixel coordinate and colour widths
//   - TRANSPARENT_COLOUR : colour that is suppressed on layers above 0 when
//                          the TRANSPARENT_EN build macro is defined
package draw_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DRAW   = 3'd2,
        NEXT   = 3'd3,
        FINISH = 3'd4
    } draw_state_e;

    localparam int unsigned DEFAULT_X_W      = 9;
    localparam int unsigned DEFAULT_Y_W      = 8;
    localparam int unsigned DEFAULT_COLOUR_W = 6;

    localparam logic [5:0] TRANSPARENT_COLOUR = 6'b000000;

endpackage

// File: rtl/frame_ticker.sv
// frame_ticker: free-running frame counter, 0 .. FRAME_COUNT-1, wrapping.
// Ports:
//   clock      in  system clock
//   reset      in  asynchronous active-high reset (counter -> 0)
//   frame_tick out high in the cycle the count equals FRAME_COUNT-1
module frame_ticker #(
    parameter int unsigned FRAME_COUNT = 1000000
) (
    input  logic clock,
    input  logic reset,
    output logic frame_tick
);

    localparam int unsigned CNT_W = (FRAME_COUNT > 2) ? $clog2(FRAME_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_COUNT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        frame_tick = (count_q == LAST);
        count_d    = frame_tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame draw sequencer feeding the VGA write port.
// On each frame tick it runs the enabled layers in index order (0 first),
// routing the active layer's pixel stream to a registered VGA output.
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   layer_mask            layer enables, sampled on the frame tick
//   layer_start           one-cycle start pulse per layer
//   layer_done            per-layer finished flag (only the active one is used)
//   layer_x/y/colour/write flattened per-layer pixel streams
//   vga_x/y/colour/write  registered pixel output
//   frame_tick            one-cycle pulse at each frame boundary
//   frame_done            one-cycle pulse when a frame's layers are complete
//   busy                  high whenever the sequencer is not idle
//   active_layer          index of the current layer
//   overrun_count         saturating count of ticks that arrived while busy
// Build macro:
//   TRANSPARENT_EN        suppress writes of TRANSPARENT_COLOUR on layers > 0
module draw_sequencer
    import draw_pkg::*;
#(
    parameter int unsigned NUM_LAYERS  = 4,
    parameter int unsigned X_W         = DEFAULT_X_W,
    parameter int unsigned Y_W         = DEFAULT_Y_W,
    parameter int unsigned COLOUR_W    = DEFAULT_COLOUR_W,
    parameter int unsigned FRAME_COUNT = 1000000,
    localparam int unsigned AL_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_LAYERS-1:0]          layer_mask,
    output logic [NUM_LAYERS-1:0]          layer_start,
    input  logic [NUM_LAYERS-1:0]          layer_done,
    input  logic [NUM_LAYERS*X_W-1:0]      layer_x,
    input  logic [NUM_LAYERS*Y_W-1:0]      layer_y,
    input  logic [NUM_LAYERS*COLOUR_W-1:0] layer_colour,
    input  logic [NUM_LAYERS-1:0]          layer_write,
    output logic [X_W-1:0]                 vga_x,
    output logic [Y_W-1:0]                 vga_y,
    output logic [COLOUR_W-1:0]            vga_colour,
    output logic                           vga_write,
    output logic                           frame_tick,
    output logic                           frame_done,
    output logic                           busy,
    output logic [AL_W-1:0]                active_layer,
    output logic [7:0]                     overrun_count
);

    draw_state_e           state_q, state_d;
    logic [NUM_LAYERS-1:0] mask_q, mask_d;
    logic [AL_W-1:0]       active_layer_q, active_layer_d;
    logic [7:0]            overrun_q, overrun_d;
    logic [X_W-1:0]        vga_x_q, vga_x_d;
    logic [Y_W-1:0]        vga_y_q, vga_y_d;
    logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
    logic                  vga_write_q, vga_write_d;

    logic                  tick;

    // Active-layer pixel mux
    logic [X_W-1:0]        sel_x;
    logic [Y_W-1:0]        sel_y;
    logic [COLOUR_W-1:0]   sel_colour;
    logic                  sel_write;
    logic                  sel_done;

    // Priority encoders
    logic                  first_found;
    logic [AL_W-1:0]       first_idx;
    logic                  next_found;
    logic [AL_W-1:0]       next_idx;

    frame_ticker #(
        .FRAME_COUNT(FRAME_COUNT)
    ) u_frame_ticker (
        .clock     (clock),
        .reset     (reset),
        .frame_tick(tick)
    );

    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_write  = 1'b0;
        sel_done   = 1'b0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (active_layer_q == AL_W'(i)) begin
                sel_x      = layer_x[i*X_W +: X_W];
                sel_y      = layer_y[i*Y_W +: Y_W];
                sel_colour = layer_colour[i*COLOUR_W +: COLOUR_W];
                sel_write  = layer_write[i];
                sel_done   = layer_done[i];
            end
        end
    end

    // Lowest enabled layer of the incoming mask, and lowest enabled layer of
    // the latched mask strictly above the current one.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (layer_mask[i] && !first_found) begin
                first_found = 1'b1;
                first_idx   = AL_W'(i);
            end
            if (mask_q[i] && (i > 32'(active_layer_q)) && !next_found) begin
                next_found = 1'b1;
                next_idx   = AL_W'(i);
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        active_layer_d = active_layer_q;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    mask_d = layer_mask;
                    if (first_found) begin
                        active_layer_d = first_idx;
                        state_d        = START;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            START:  state_d = DRAW;
            DRAW: begin
                if (sel_done) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (next_found) begin
                    active_layer_d = next_idx;
                    state_d        = START;
                end else begin
                    state_d = FINISH;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A tick arriving mid-frame is dropped; only the counter records it.
    always_comb begin
        overrun_d = overrun_q;
        if (tick && (state_q != IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    // Coordinates and colour follow the active layer in every state; only the
    // write strobe is gated, and it is dropped in the cycle done is raised.
    always_comb begin
        vga_x_d      = sel_x;
        vga_y_d      = sel_y;
        vga_colour_d = sel_colour;
        vga_write_d  = (state_q == DRAW) && sel_write && !sel_done;
`ifdef TRANSPARENT_EN
        if ((active_layer_q != '0) &&
            (sel_colour == COLOUR_W'(TRANSPARENT_COLOUR))) begin
            vga_write_d = 1'b0;
        end
`endif
    end

    always_comb begin
        layer_start = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if ((state_q == START) && (active_layer_q == AL_W'(i))) begin
                layer_start[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            mask_q         <= '0;
            active_layer_q <= '0;
            overrun_q      <= '0;
            vga_x_q        <= '0;
            vga_y_q        <= '0;
            vga_colour_q   <= '0;
            vga_write_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            mask_q         <= mask_d;
            active_layer_q <= active_layer_d;
            overrun_q      <= overrun_d;
            vga_x_q        <= vga_x_d;
            vga_y_q        <= vga_y_d;
            vga_colour_q   <= vga_colour_d;
            vga_write_q    <= vga_write_d;
        end
    end

    assign vga_x         = vga_x_q;
    assign vga_y         = vga_y_q;
    assign vga_colour    = vga_colour_q;
    assign vga_write     = vga_write_q;
    assign frame_tick    = tick;
    assign frame_done    = (state_q == FINISH);
    assign busy          = (state_q != IDLE);
    assign active_layer  = active_layer_q;
    assign overrun_count = overrun_q;

endmodule
